// File: rtl/latent_frame_deserializer.sv
// latent_frame_deserializer
// Receive side of the autoencoder latent link. Reassembles LANE_W-bit beats
// into one ACT_W*N_LATENT-bit latent vector and hands it to the decoder over
// a valid/ready handshake. Frames with the wrong beat count are dropped and
// counted. Double-buffered: an assembly register collects the next frame
// while the output register holds the current one.
module latent_frame_deserializer #(
    parameter int unsigned ACT_W    = 2,
    parameter int unsigned N_LATENT = 16,
    parameter int unsigned LANE_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANE_W-1:0]         s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic [ACT_W*N_LATENT-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      err_pulse,
    output logic [15:0]               frame_cnt,
    output logic [7:0]                err_cnt
);

    localparam int unsigned VEC_W = ACT_W * N_LATENT;
    localparam int unsigned BEATS = VEC_W / LANE_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

    // Reject geometries where beats do not tile the vector or activations
    // straddle a beat boundary.
    if (((VEC_W % LANE_W) != 0) || ((LANE_W % ACT_W) != 0) || (BEATS == 0)) begin : g_bad_cfg
        $error("latent_frame_deserializer: ACT_W*N_LATENT must be a multiple of LANE_W and LANE_W a multiple of ACT_W");
    end

    typedef enum logic {
        COLLECT,
        DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   asm_q, asm_d;
    logic [VEC_W-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               pending_q, pending_d;
    logic               err_pulse_q, err_pulse_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               live_q;

    logic               accept;
    logic               out_take;
    logic               out_free;
    logic               complete;
    logic               drop;
    logic [VEC_W-1:0]   merged_vec;

    // s_ready depends only on flops: no path from m_ready or s_data.
    assign s_ready   = live_q && !pending_q;
    assign accept    = s_valid && s_ready;
    assign out_take  = m_valid_q && m_ready;
    assign out_free  = !m_valid_q || m_ready;

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign err_pulse = err_pulse_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

    // Assembly register with the incoming beat merged into the current slot.
    always_comb begin
        merged_vec = asm_q;
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
                merged_vec[b*LANE_W +: LANE_W] = s_data;
            end
        end
    end

    // Next-state: frame framing FSM, output handoff, and counters.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        pending_d   = pending_q;
        err_pulse_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        complete    = 1'b0;
        drop        = 1'b0;

        if (accept) begin
            unique case (state_q)
                COLLECT: begin
                    asm_d = merged_vec;
                    if (cnt_q == LAST_SLOT) begin
                        cnt_d = '0;
                        if (s_last) begin
                            complete = 1'b1;
                        end else begin
                            drop    = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        drop  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DISCARD: begin
                    if (s_last) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end

        // A completion and a pending reload never coincide: s_ready is low
        // while pending, so no beat (and hence no completion) can be accepted.
        if (complete && out_free) begin
            m_data_d    = merged_vec;
            m_valid_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (complete) begin
            pending_d   = 1'b1;
        end else if (pending_q && out_take) begin
            m_data_d    = asm_q;
            m_valid_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            pending_d   = 1'b0;
        end else if (out_take) begin
            m_valid_d   = 1'b0;
        end

        if (drop) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset silently discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            pending_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            pending_q   <= pending_d;
            err_pulse_q <= err_pulse_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            live_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_latent_frame_deserializer.sv
// tb_latent_frame_deserializer
// Directed and randomized stimulus for latent_frame_deserializer. A monitor
// builds the expected output stream from the beats actually accepted:
// a frame of exactly BEATS beats ending in s_last yields one vector, any
// other length is one dropped frame.
module tb_latent_frame_deserializer;

    localparam int unsigned ACT_W    = 2;
    localparam int unsigned N_LATENT = 16;
    localparam int unsigned LANE_W   = 8;
    localparam int unsigned BEATS    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        err_pulse;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  part[$];
    logic [31:0] exp_q[$];
    int unsigned model_frames = 0;
    int unsigned model_drops  = 0;
    int unsigned pulses       = 0;
    logic        hold         = 1'b0;
    logic [31:0] hold_data    = '0;
    logic        rand_mode    = 1'b0;

    latent_frame_deserializer #(
        .ACT_W   (ACT_W),
        .N_LATENT(N_LATENT),
        .LANE_W  (LANE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_pulse(err_pulse),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: sample mid-cycle, maintain the frame-level model, check outputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            part.delete();
            exp_q.delete();
            model_frames = 0;
            model_drops  = 0;
            pulses       = 0;
            hold         = 1'b0;
        end else begin
            if (hold) chk("m_data_stable", m_data, hold_data);
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            if (err_pulse) pulses++;
            if (s_valid && s_ready) begin
                part.push_back(s_data);
                if (s_last) begin
                    if (part.size() == BEATS) begin
                        logic [31:0] v;
                        v = '0;
                        foreach (part[i]) v[i*8 +: 8] = part[i];
                        exp_q.push_back(v);
                        model_frames++;
                    end else begin
                        model_drops++;
                    end
                    part.delete();
                end
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("out_vector", m_data, exp_q.pop_front());
                end
            end
        end
    end

    // Random backpressure during the randomized phase.
    always @(posedge clk) begin
        #1;
        if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_beat(input logic [7:0] d, input logic l, output int unsigned stalls);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        stalls  = 0;
        @(negedge clk);
        while (!s_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_ready) chk("accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] v, output int unsigned stalls);
        int unsigned st;
        stalls = 0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            send_beat(v[b*8 +: 8], b == BEATS - 1, st);
            stalls += st;
        end
    endtask

    task automatic idle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned st, st_total, len, n;
        logic [31:0] fa, fb;

        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        idle();
        chk("s_ready_after_release", 32'(s_ready), 32'd1);

        // Nominal frame
        m_ready = 1'b1;
        send_frame(32'h00FF1BE4, st);
        chk("nom_m_valid", 32'(m_valid), 32'd1);
        chk("nom_m_data", m_data, 32'h00FF1BE4);
        chk("nom_frame_cnt", 32'(frame_cnt), 32'd1);
        idle();
        chk("nom_m_valid_fall", 32'(m_valid), 32'd0);

        // Back-to-back frames, no stalls expected
        fa = $urandom();
        fb = $urandom();
        send_frame(fa, st_total);
        chk("b2b_first", m_data, fa);
        send_frame(fb, st);
        st_total += st;
        chk("b2b_second", m_data, fb);
        chk("b2b_no_stall", st_total, 32'd0);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd3);
        idle();

        // Backpressure: A held, B pending
        m_ready = 1'b0;
        fa = $urandom();
        fb = $urandom();
        send_frame(fa, st);
        send_frame(fb, st);
        chk("bp_s_ready_low", 32'(s_ready), 32'd0);
        chk("bp_hold_a", m_data, fa);
        repeat (3) idle();
        chk("bp_still_a", m_data, fa);
        chk("bp_still_blocked", 32'(s_ready), 32'd0);
        m_ready = 1'b1;
        idle();
        chk("bp_b_presented", m_data, fb);
        chk("bp_b_valid", 32'(m_valid), 32'd1);
        chk("bp_s_ready_back", 32'(s_ready), 32'd1);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd5);
        idle();
        chk("bp_drained", 32'(m_valid), 32'd0);

        // Short frame
        send_beat(8'h12, 1'b0, st);
        send_beat(8'h34, 1'b1, st);
        chk("short_pulse", 32'(err_pulse), 32'd1);
        chk("short_no_valid", 32'(m_valid), 32'd0);
        idle();
        chk("short_pulse_one_cycle", 32'(err_pulse), 32'd0);
        chk("short_err_cnt", 32'(err_cnt), 32'd1);
        fa = $urandom();
        send_frame(fa, st);
        chk("short_next_frame", m_data, fa);
        chk("short_frame_cnt", 32'(frame_cnt), 32'd6);
        idle();

        // Long frame: 6 beats
        for (int unsigned b = 0; b < 6; b++) begin
            send_beat(8'($urandom()), b == 5, st);
            if (b == 3) chk("long_pulse_at_beat4", 32'(err_pulse), 32'd1);
            if (b == 4) chk("long_no_second_pulse", 32'(err_pulse), 32'd0);
        end
        chk("long_tail_no_pulse", 32'(err_pulse), 32'd0);
        chk("long_err_cnt", 32'(err_cnt), 32'd2);
        chk("long_no_valid", 32'(m_valid), 32'd0);
        fa = $urandom();
        send_frame(fa, st);
        chk("long_next_frame", m_data, fa);
        chk("long_frame_cnt", 32'(frame_cnt), 32'd7);
        idle();

        // Reset mid-frame
        send_beat(8'hAA, 1'b0, st);
        send_beat(8'h55, 1'b0, st);
        rst_n = 1'b0;
        #2;
        chk("midrst_s_ready", 32'(s_ready), 32'd0);
        chk("midrst_m_data", m_data, 32'd0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        fa = $urandom();
        send_frame(fa, st);
        chk("midrst_new_frame", m_data, fa);
        chk("midrst_frame_cnt_after", 32'(frame_cnt), 32'd1);
        chk("midrst_err_cnt_after", 32'(err_cnt), 32'd0);
        idle();

        // Randomized frames with random backpressure
        rand_mode = 1'b1;
        for (int f = 0; f < 60; f++) begin
            len = ($urandom_range(0, 9) < 7) ? BEATS : $urandom_range(1, 6);
            for (int unsigned b = 0; b < len; b++) begin
                send_beat(8'($urandom()), b == len - 1, st);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        n = 0;
        while (m_valid && n < 50) begin
            idle();
            n++;
        end
        chk("rand_drained", 32'(m_valid), 32'd0);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rand_frame_cnt", 32'(frame_cnt), 32'(model_frames & 32'hFFFF));
        chk("rand_err_cnt", 32'(err_cnt), (model_drops > 255) ? 32'd255 : model_drops);
        chk("rand_pulses", pulses, model_drops);

        // Error counter saturation
        for (int k = 0; k < 260; k++) send_beat(8'($urandom()), 1'b1, st);
        idle();
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_pulses", pulses, model_drops);
        chk("sat_no_valid", 32'(m_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
